// File: rtl/polar_to_rect.sv
// Iterative rotation-mode CORDIC: first-quadrant (r, theta in degrees) -> rounded (x, y).
// Define P2R_GAIN_COMP_EN to pre-scale r by K~0.60725; otherwise outputs carry the CORDIC gain.
module polar_to_rect #(
  parameter int ITER = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] r,
  input  logic [7:0] theta,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       err,
  output logic       ovf
);

  // Handshake: start is honoured only in IDLE; busy is high from the accepted
  // start edge until the edge that raises the one-cycle done pulse.
  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t             state, state_next;
  logic signed [17:0] xr, yr;
  logic signed [15:0] z;
  logic [3:0]         i;
  logic [7:0]         th_sat;
  logic [17:0]        xr_load;
  logic signed [17:0] xs, ys;
  logic [8:0]         x_res, y_res;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 16'sd11520;
      4'd1:    atan_lut = 16'sd6801;
      4'd2:    atan_lut = 16'sd3593;
      4'd3:    atan_lut = 16'sd1824;
      4'd4:    atan_lut = 16'sd916;
      4'd5:    atan_lut = 16'sd458;
      4'd6:    atan_lut = 16'sd229;
      4'd7:    atan_lut = 16'sd115;
      4'd8:    atan_lut = 16'sd57;
      4'd9:    atan_lut = 16'sd29;
      4'd10:   atan_lut = 16'sd14;
      4'd11:   atan_lut = 16'sd7;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  // Round Q10.8 to integer, clamp to 0..255; MSB flags an upper clamp only.
  function automatic logic [8:0] round_sat(input logic signed [17:0] v);
    logic signed [17:0] rv;
    logic signed [9:0]  q;
    rv = v + 18'sd128;
    q  = 10'(rv >>> 8);
    if (q[9])
      round_sat = 9'd0;
    else if (q > 10'sd255)
      round_sat = {1'b1, 8'd255};
    else
      round_sat = {1'b0, q[7:0]};
  endfunction

  assign th_sat = (theta > 8'd90) ? 8'd90 : theta;

`ifdef P2R_GAIN_COMP_EN
  assign xr_load = 18'((r * 24'd39797) >> 8);
`else
  assign xr_load = {2'b00, r, 8'd0};
`endif

  assign xs    = xr >>> i;
  assign ys    = yr >>> i;
  assign x_res = round_sat(xr);
  assign y_res = round_sat(yr);
  assign busy  = (state != S_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ROTATE;
      S_ROTATE: if (i == LAST) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      xr    <= '0;
      yr    <= '0;
      z     <= '0;
      i     <= '0;
      x     <= '0;
      y     <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            z   <= signed'({th_sat, 8'd0});
            xr  <= signed'(xr_load);
            yr  <= '0;
            i   <= '0;
            err <= (theta > 8'd90);
          end
        end
        S_ROTATE: begin
          // Direction follows the sign of the remaining angle.
          if (!z[15]) begin
            xr <= xr - ys;
            yr <= yr + xs;
            z  <= z - atan_lut(i);
          end else begin
            xr <= xr + ys;
            yr <= yr - xs;
            z  <= z + atan_lut(i);
          end
          i <= i + 4'd1;
        end
        S_DONE: begin
          x    <= x_res[7:0];
          y    <= y_res[7:0];
          ovf  <= x_res[8] | y_res[8];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_to_rect.sv
// Self-checking bench for polar_to_rect: directed points, randomized conversions
// against a trigonometric reference, abort-by-reset and held-start throughput.
module tb_polar_to_rect;

  localparam int ITER = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] r = 8'd0;
  logic [7:0] theta = 8'd0;
  logic       busy, done, err, ovf;
  logic [7:0] x, y;

  int  checks = 0;
  int  failures = 0;
  real gain;

`ifdef P2R_GAIN_COMP_EN
  localparam int N_DIR = 6;
  int d_r[N_DIR] = '{10, 10, 5, 10, 255, 20};
  int d_t[N_DIR] = '{0, 90, 53, 53, 45, 120};
  int d_x[N_DIR] = '{10, 0, 3, 6, 180, 0};
  int d_y[N_DIR] = '{0, 10, 4, 8, 180, 20};
  int d_o[N_DIR] = '{0, 0, 0, 0, 0, 0};
`else
  localparam int N_DIR = 4;
  int d_r[N_DIR] = '{10, 10, 200, 20};
  int d_t[N_DIR] = '{0, 90, 0, 120};
  int d_x[N_DIR] = '{16, 0, 255, 0};
  int d_y[N_DIR] = '{0, 16, 0, 33};
  int d_o[N_DIR] = '{0, 0, 1, 0};
`endif

  polar_to_rect #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .r(r), .theta(theta),
    .busy(busy), .done(done), .x(x), .y(y), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: ideal r*cos / r*sin (times the CORDIC gain when uncompensated).
  function automatic real ideal(input int rr, input int th, input bit want_y);
    real a;
    a = ((th > 90) ? 90 : th) * 3.14159265358979 / 180.0;
    return rr * gain * (want_y ? $sin(a) : $cos(a));
  endfunction

  function automatic int clamp_round(input real v);
    int n;
    if (v < 0.0) return 0;
    n = $rtoi(v + 0.5);
    return (n > 255) ? 255 : n;
  endfunction

  // Drives one request from the current (post-edge) time, checks handshake timing,
  // returns once the done cycle has been sampled plus one more cycle.
  task automatic run_conv(input int rr, input int th, input bit disturb);
    int lat;
    lat = -1;
    r = 8'(rr);
    theta = 8'(th);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== (th > 90)) begin
      failures++;
      $display("FAIL load_flags r=%0d th=%0d: busy=%b err=%b, required busy=1 err=%b", rr, th, busy, err, th > 90);
    end
    for (int k = 1; k <= ITER + 5; k++) begin
      @(posedge clk); #1;
      if (disturb && k == 3) begin
        r = 8'($urandom_range(0, 255));
        theta = 8'($urandom_range(0, 90));
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != ITER + 1) begin
      failures++;
      $display("FAIL latency r=%0d th=%0d: got %0d cycles, required %0d", rr, th, lat, ITER + 1);
    end
    checks++;
    if (busy !== 1'b0 || err !== (th > 90)) begin
      failures++;
      $display("FAIL done_flags r=%0d th=%0d: busy=%b err=%b, required busy=0 err=%b", rr, th, busy, err, th > 90);
    end
  endtask

  task automatic wait_pulse_end;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_width: done=%b one cycle after pulse, required 0", done);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, x, y, err, ovf} !== 20'd0) begin
      failures++;
      $display("FAIL reset_values: busy=%b done=%b x=%0d y=%0d err=%b ovf=%b, required all 0", busy, done, x, y, err, ovf);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    for (int n = 0; n < N_DIR; n++) begin
      run_conv(d_r[n], d_t[n], 1'b0);
      checks++;
      if (x !== 8'(d_x[n]) || y !== 8'(d_y[n]) || ovf !== d_o[n][0]) begin
        failures++;
        $display("FAIL directed r=%0d th=%0d: x=%0d y=%0d ovf=%b, required x=%0d y=%0d ovf=%0d",
                 d_r[n], d_t[n], x, y, ovf, d_x[n], d_y[n], d_o[n]);
      end
      wait_pulse_end();
    end
  endtask

  task automatic test_abort;
    bit seen;
    seen = 1'b0;
    run_conv(77, 20, 1'b0);
    wait_pulse_end();
    r = 8'd50;
    theta = 8'd30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, x, y, err, ovf} !== 20'd0) begin
      failures++;
      $display("FAIL abort_values: busy=%b done=%b x=%0d y=%0d err=%b ovf=%b, required all 0", busy, done, x, y, err, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: done_seen=%b busy=%b, required 0 and 0", seen, busy);
    end
  endtask

  task automatic test_random(input int count, input bit disturb);
    int rr, th, ex, ey, dx, dy;
    real vx, vy;
    for (int n = 0; n < count; n++) begin
      rr = $urandom_range(0, 255);
      th = $urandom_range(0, 110);
      vx = ideal(rr, th, 1'b0);
      vy = ideal(rr, th, 1'b1);
      ex = clamp_round(vx);
      ey = clamp_round(vy);
      run_conv(rr, th, disturb);
      dx = int'(x) - ex;
      dy = int'(y) - ey;
      checks++;
      if (dx > 1 || dx < -1 || dy > 1 || dy < -1) begin
        failures++;
        $display("FAIL random_xy r=%0d th=%0d: x=%0d y=%0d, required x=%0d y=%0d (+-1)", rr, th, x, y, ex, ey);
      end
      if (vx < 254.4 && vy < 254.4) begin
        checks++;
        if (ovf !== 1'b0) begin
          failures++;
          $display("FAIL random_ovf r=%0d th=%0d: ovf=%b, required 0", rr, th, ovf);
        end
      end else if (vx > 256.0 || vy > 256.0) begin
        checks++;
        if (ovf !== 1'b1) begin
          failures++;
          $display("FAIL random_ovf r=%0d th=%0d: ovf=%b, required 1", rr, th, ovf);
        end
      end
      wait_pulse_end();
    end
  endtask

  task automatic test_back_to_back;
    int cyc, low;
    int done_at[$];
    cyc = 0;
    low = 0;
    r = 8'($urandom_range(0, 255));
    theta = 8'($urandom_range(0, 90));
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) done_at.push_back(cyc);
      if (done_at.size() >= 1 && done_at.size() < 3 && !busy) low++;
    end
    start = 1'b0;
    checks++;
    if (done_at.size() < 3) begin
      failures++;
      $display("FAIL b2b_count: %0d results in 60 cycles, required at least 3", done_at.size());
    end else begin
      checks++;
      if (done_at[1] - done_at[0] != ITER + 2 || done_at[2] - done_at[1] != ITER + 2) begin
        failures++;
        $display("FAIL b2b_period: gaps %0d,%0d, required %0d", done_at[1] - done_at[0], done_at[2] - done_at[1], ITER + 2);
      end
      checks++;
      if (low != 2) begin
        failures++;
        $display("FAIL b2b_busy_gap: %0d busy-low cycles over two gaps, required 2", low);
      end
    end
    repeat (ITER + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    gain = 1.0;
`ifndef P2R_GAIN_COMP_EN
    begin
      real p;
      p = 1.0;
      for (int k = 0; k < ITER; k++) begin
        gain = gain * $sqrt(1.0 + p);
        p = p / 4.0;
      end
    end
`endif
    test_reset();
    test_directed();
    test_abort();
    test_random(30, 1'b0);
    test_random(6, 1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polar_to_rect.md
# polar_to_rect

Iterative CORDIC engine, rotation mode, that converts a first-quadrant polar pair (r, theta in degrees) into rectangular (x, y). It is the inverse companion of the rectangular-to-cylindrical block and sits beside it in the tile, sharing its 8-bit operand conventions. One conversion runs at a time under a start/busy/done handshake. Results are held until the next conversion completes.

## Interface
- ITER, 12: CORDIC iterations; legal range 8..12.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- r  in  8  unsigned magnitude
- theta  in  8  unsigned angle in integer degrees; legal range 0..90
- busy  out  1  high from the accepted start edge until done
- done  out  1  one-cycle pulse when x/y update
- x  out  8  unsigned r·cos(theta), rounded
- y  out  8  unsigned r·sin(theta), rounded
- err  out  1  theta>90 on the last accepted request; held with x/y
- ovf  out  1  x or y saturated on the last result; held with x/y

## Operation
- Reset: state IDLE, busy=0, done=0, x=0, y=0, err=0, ovf=0, and all internal registers 0.
- States and transitions:
  - IDLE: go to ROTATE when start=1; otherwise stay.
  - ROTATE: go to DONE after ITER iterations.
  - DONE: go to IDLE.
- Load, on the start edge in IDLE:
  - z = min(theta,90)·256. z is 16-bit signed degrees, Q8.8.
  - xr = r·39797 >> 8. xr is 18-bit signed, Q10.8, and carries the CORDIC gain compensation K≈0.60725 in Q16.
  - yr = 0; iteration counter i = 0.
  - Capture err = (theta>90).
- Each ROTATE cycle:
  - d = (z ≥ 0) ? +1 : −1.
  - xr −= d·(yr >>> i); yr += d·(xr >>> i); z −= d·ATAN[i]. All right-hand sides use the pre-update values. Shifts are arithmetic.
  - i increments.
- ATAN table, degrees·256, index 0..11: 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7.
- DONE:
  - x = clamp((xr+128)>>>8, 0, 255); y likewise from yr.
  - ovf=1 if either value was clamped. Negative residue near 0°/90° clamps to 0 and does not set ovf.
  - done=1 for this cycle.
- start while busy or in DONE is ignored (not queued).
- Inputs are captured at load only; changes to r or theta during ROTATE have no effect.
- Asynchronous rst mid-conversion aborts immediately to reset values. No done is issued.

## Timing
- The start edge is edge N.
- Iterations run on edges N+1..N+ITER.
- Edge N+ITER+1: x/y/ovf update and done rises. Latency is ITER+1 cycles (13 by default).
- busy goes high at edge N and low at edge N+ITER+1, together with done rising.
- The earliest next accepted start is edge N+ITER+2. Throughput is one result per ITER+2 cycles.
- done is never asserted for two consecutive cycles.
- err updates at edge N, so it is visible while busy.

## Configuration
- P2R_GAIN_COMP_EN defined:
  - xr load = r·39797 >> 8.
  - Outputs are true r·cos/r·sin.
  - ovf is only possible through rounding at r=255.
- P2R_GAIN_COMP_EN undefined:
  - xr load = r<<8; the multiplier is removed.
  - Outputs are scaled by the CORDIC gain ≈1.6468 and saturate at 255 with ovf=1.
  - Downstream is responsible for scaling.

## Test plan
- Reset values: assert rst mid-ROTATE -> all outputs 0 immediately; after release, done never pulses for the aborted request.
- Quadrant edges: r=10 with theta=0, then theta=90 -> x=10,y=0 then x=0,y=10; done exactly 13 cycles after each start; err=0.
- Triangles: r=5,theta=53 -> x=3,y=4; r=10,theta=53 -> x=6,y=8; r=255,theta=45 -> x=180,y=180.
- Out-of-range angle: r=20,theta=120 -> err=1 from edge N, x=0,y=20 at done.
- Handshake:
  - Hold start high continuously -> results every 14 cycles; busy low exactly one cycle between them.
  - Changing r during ROTATE -> result unaffected.
- Gain compensation off (P2R_GAIN_COMP_EN undefined): r=10,theta=0 -> x=16,y=0,ovf=0; r=200,theta=0 -> x=255,ovf=1.
